mc6845_crtc: RTL and testbench
==============================

# mc6845_crtc

Synthesizable model of the Motorola MC6845 CRT controller used for video timing. A CPU-side register file (address register plus R0–R17) programs horizontal and vertical character timing. A character-rate counter chain produces the framestore address, scanline row, display enable, horizontal/vertical sync and cursor outputs. It sits between the CPU bus and the video serializer; all logic is clocked by the character clock and qualified by a clock enable.

## Interface
- No parameters.
- char_clk  in  1  character clock; all state updates on rising edge.
- nRESET  in  1  synchronous active-low reset.
- en  in  1  clock enable; state advances and bus accesses happen only when high.
- nCS  in  1  chip select, active low.
- RnW  in  1  1 = read, 0 = write.
- RS  in  1  0 = address register, 1 = data register.
- LPSTB  in  1  light-pen strobe, active high.
- data_bus  inout  8  CPU data; driven by the DUT only when ~nCS & RnW & en, else Z.
- framestore_adr  out  14  refresh memory address.
- scanline_row  out  5  scanline within the current character row.
- display_en  out  1  active display region.
- h_sync, v_sync  out  1  sync pulses, active high.
- cursor  out  1  cursor video.

## Operation
- **Register writes** (en & ~nCS & ~RnW):
  - RS=0 latches data[4:0] into the address register.
  - RS=1 writes the selected register; addresses ≥16 are ignored on write.
  - Writes are accepted while nRESET=0. The register file is not cleared by reset.
- **Register map**:
  - R0 H total−1; R1 H displayed; R2 H sync position.
  - R3 sync widths: [3:0] H sync in chars, [7:4] V sync in scanlines; 0 means 16.
  - R4 V total−1 (rows, 7 bit); R5 V adjust scanlines (5 bit); R6 V displayed rows; R7 V sync row.
  - R8 interlace: stored only; non-interlaced operation always.
  - R9 max scanline (5 bit).
  - R10 [6:5] blink mode, [4:0] cursor start line; R11 cursor end line.
  - R12/R13 start address hi[5:0]/lo; R14/R15 cursor address hi[5:0]/lo; R16/R17 light pen hi/lo.
- **Reads**: R14–R17 readable; all others read 0.
- **Horizontal**: hc counts 0..R0, then wraps to 0.
  - h_sync is high for the R3[3:0] chars starting at hc==R2.
- **Vertical**:
  - At hc==R0, the scanline counter ra advances 0..R9.
  - At ra==R9, the row counter advances 0..R4.
  - After row R4 completes, R5 extra scanlines follow, then a new frame starts (R5=0 skips the adjust).
  - v_sync rises at the start of row R7 (ra=0, hc=0) and lasts R3[7:4] scanlines.
- **Address generation**:
  - Row start loads R12:R13 at frame start.
  - At hc==R1 on the last scanline of a row, row start += R1.
  - framestore_adr = row start + hc, modulo 2^14.
  - scanline_row = ra.
- **display_en** = (hc < R1) & (row < R6) & not in vertical adjust.
- **cursor** = display_en & (framestore_adr == R14:R15) & (R10[4:0] ≤ ra ≤ R11) & blink_on.
  - Blink modes: 00 steady on; 01 off; 10 toggle every 16 fields; 11 toggle every 32 fields.
  - The field counter increments at frame start.

## Timing
- Counters are registered. Outputs are decoded from the current counter state and are valid in the same cycle.
- Counters hold while en=0.
- **nRESET=0**:
  - hc, ra, row, field counter and syncs are cleared.
  - display_en=0, h_sync=0, v_sync=0, cursor=0, framestore_adr=0, scanline_row=0.
- **Reset release**:
  - The first enabled cycle presents hc=0, ra=0, row=0, framestore_adr=R12:R13.
- Register changes take effect at the next comparison; there is no shadowing.
- **Overlapping sync windows**: if a sync window crosses a line or frame wrap, it continues for its full width.

## Configuration
- MC6845_LIGHTPEN_EN defined: on an enabled cycle where the LPSTB rising edge is detected (registered previous value), framestore_adr is captured into R16/R17.
- MC6845_LIGHTPEN_EN undefined: LPSTB is ignored; R16/R17 read 0.

## Structure
- Shared package mc6845_pkg holds the register index constants (H_TOTAL=0 … CURSOR_ADDRESS_LO=15, LPEN_HI=16, LPEN_LO=17) and the blink-mode encodings.
- One natural sub-module: mc6845_regfile (address register, R0–R17, read mux, bus tri-state). The timing chain stays in the top module.

## Test plan
Programming for all scenarios, written under reset: R0=16, R1=10, R2=12, R3=0x34, R4=18, R5=2, R6=12, R7=14, R9=3, R10=0x41, R11=2, R12:R13=0x0080, R14:R15=0x0080.
- **Reset/programming**: reset high, writes applied → all outputs 0 during reset; first cycle after release framestore_adr=128, scanline_row=0, display_en=1.
- **Horizontal**: line period is 17 clocks; display_en high for 10 clocks; h_sync high on hc 12–15.
- **Vertical**: frame period is (19×4+2)×17 = 1326 clocks; display_en rows 0–11 only; v_sync rises at row 14 and lasts 3 scanlines.
- **Addressing**: rows 0, 1, 2 start at 128, 138, 148; framestore_adr is constant across the 4 scanlines of a row.
- **Cursor**: high only at address 128 on scanlines 1–2 of row 0; present in frames 0–15, absent in frames 16–31.
- **Bus/light pen**:
  - R14 read returns 0x00 with data_bus driven; R0 read returns 0.
  - With MC6845_LIGHTPEN_EN defined, an LPSTB pulse at framestore_adr=133 makes R16:R17 read 0x0085.

Source files
------------

// File: rtl/mc6845_pkg.sv
// Shared definitions for the MC6845 CRTC model: register indices,
// blink-mode encodings, the decoded configuration bundle and a
// helper that expands the 4-bit sync width fields (0 encodes 16).
package mc6845_pkg;

  localparam logic [4:0] H_TOTAL           = 5'd0;
  localparam logic [4:0] H_DISPLAYED       = 5'd1;
  localparam logic [4:0] H_SYNC_POS        = 5'd2;
  localparam logic [4:0] SYNC_WIDTH        = 5'd3;
  localparam logic [4:0] V_TOTAL           = 5'd4;
  localparam logic [4:0] V_TOTAL_ADJ       = 5'd5;
  localparam logic [4:0] V_DISPLAYED       = 5'd6;
  localparam logic [4:0] V_SYNC_POS        = 5'd7;
  localparam logic [4:0] INTERLACE_MODE    = 5'd8;
  localparam logic [4:0] MAX_SCANLINE      = 5'd9;
  localparam logic [4:0] CURSOR_START      = 5'd10;
  localparam logic [4:0] CURSOR_END        = 5'd11;
  localparam logic [4:0] START_ADDR_HI     = 5'd12;
  localparam logic [4:0] START_ADDR_LO     = 5'd13;
  localparam logic [4:0] CURSOR_ADDRESS_HI = 5'd14;
  localparam logic [4:0] CURSOR_ADDRESS_LO = 5'd15;
  localparam logic [4:0] LPEN_HI           = 5'd16;
  localparam logic [4:0] LPEN_LO           = 5'd17;

  typedef enum logic [1:0] {
    BLINK_STEADY = 2'b00,
    BLINK_OFF    = 2'b01,
    BLINK_16     = 2'b10,
    BLINK_32     = 2'b11
  } blink_mode_e;

  typedef struct packed {
    logic [7:0]  h_total;
    logic [7:0]  h_disp;
    logic [7:0]  h_sync_pos;
    logic [3:0]  v_sync_w;
    logic [3:0]  h_sync_w;
    logic [6:0]  v_total;
    logic [4:0]  v_adj;
    logic [6:0]  v_disp;
    logic [6:0]  v_sync_pos;
    logic [4:0]  max_ra;
    blink_mode_e blink;
    logic [4:0]  cur_start;
    logic [4:0]  cur_end;
    logic [13:0] start_addr;
    logic [13:0] cursor_addr;
  } crtc_cfg_t;

  function automatic logic [4:0] sync_width(input logic [3:0] w);
    return (w == 4'd0) ? 5'd16 : {1'b0, w};
  endfunction

endpackage

// File: rtl/mc6845_if.sv
// CPU bus control signals of the CRTC (chip select, direction, register
// select). The data bus itself stays a plain inout on the top level.
interface mc6845_if;
  logic nCS;
  logic RnW;
  logic RS;

  modport master (output nCS, output RnW, output RS);
  modport slave  (input  nCS, input  RnW, input  RS);
endinterface

// File: rtl/mc6845_regfile.sv
// CPU-visible register file: address register, R0-R15 storage, read mux
// for R14-R17 and the read-enable for the data bus tri-state.
// Registers are deliberately not reset so software can program them
// while the timing chain is held in reset.
module mc6845_regfile
  import mc6845_pkg::*;
(
  input  logic        clk_i,
  input  logic        en_i,
  mc6845_if.slave     bus,
  input  logic [7:0]  wdata_i,
  input  logic [13:0] lpen_adr_i,
  output logic [7:0]  rdata_o,
  output logic        rd_oe_o,
  output crtc_cfg_t   cfg_o
);

  logic [4:0] addr_q;
  logic [7:0] h_total_q, h_disp_q, h_sync_pos_q, sync_w_q;
  logic [6:0] v_total_q, v_disp_q, v_sync_pos_q;
  logic [4:0] v_adj_q, max_ra_q, cur_end_q;
  logic [7:0] r8_unused_q;
  logic [6:0] cur_start_q;
  logic [5:0] start_hi_q, cur_hi_q;
  logic [7:0] start_lo_q, cur_lo_q;
  logic       wr;

  assign wr      = en_i & ~bus.nCS & ~bus.RnW;
  assign rd_oe_o = en_i & ~bus.nCS &  bus.RnW;

  // CPU writes: RS=0 selects the register, RS=1 writes it; 16+ are read-only
  always_ff @(posedge clk_i) begin
    if (wr) begin
      if (!bus.RS) begin
        addr_q <= wdata_i[4:0];
      end else begin
        case (addr_q)
          H_TOTAL:           h_total_q    <= wdata_i;
          H_DISPLAYED:       h_disp_q     <= wdata_i;
          H_SYNC_POS:        h_sync_pos_q <= wdata_i;
          SYNC_WIDTH:        sync_w_q     <= wdata_i;
          V_TOTAL:           v_total_q    <= wdata_i[6:0];
          V_TOTAL_ADJ:       v_adj_q      <= wdata_i[4:0];
          V_DISPLAYED:       v_disp_q     <= wdata_i[6:0];
          V_SYNC_POS:        v_sync_pos_q <= wdata_i[6:0];
          INTERLACE_MODE:    r8_unused_q  <= wdata_i;
          MAX_SCANLINE:      max_ra_q     <= wdata_i[4:0];
          CURSOR_START:      cur_start_q  <= wdata_i[6:0];
          CURSOR_END:        cur_end_q    <= wdata_i[4:0];
          START_ADDR_HI:     start_hi_q   <= wdata_i[5:0];
          START_ADDR_LO:     start_lo_q   <= wdata_i;
          CURSOR_ADDRESS_HI: cur_hi_q     <= wdata_i[5:0];
          CURSOR_ADDRESS_LO: cur_lo_q     <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  // Read mux: only the cursor and light-pen addresses are readable
  always_comb begin
    rdata_o = 8'h00;
    case (addr_q)
      CURSOR_ADDRESS_HI: rdata_o = {2'b00, cur_hi_q};
      CURSOR_ADDRESS_LO: rdata_o = cur_lo_q;
      LPEN_HI:           rdata_o = {2'b00, lpen_adr_i[13:8]};
      LPEN_LO:           rdata_o = lpen_adr_i[7:0];
      default:           rdata_o = 8'h00;
    endcase
  end

  assign cfg_o.h_total     = h_total_q;
  assign cfg_o.h_disp      = h_disp_q;
  assign cfg_o.h_sync_pos  = h_sync_pos_q;
  assign cfg_o.v_sync_w    = sync_w_q[7:4];
  assign cfg_o.h_sync_w    = sync_w_q[3:0];
  assign cfg_o.v_total     = v_total_q;
  assign cfg_o.v_adj       = v_adj_q;
  assign cfg_o.v_disp      = v_disp_q;
  assign cfg_o.v_sync_pos  = v_sync_pos_q;
  assign cfg_o.max_ra      = max_ra_q;
  assign cfg_o.blink       = blink_mode_e'(cur_start_q[6:5]);
  assign cfg_o.cur_start   = cur_start_q[4:0];
  assign cfg_o.cur_end     = cur_end_q;
  assign cfg_o.start_addr  = {start_hi_q, start_lo_q};
  assign cfg_o.cursor_addr = {cur_hi_q, cur_lo_q};

endmodule

// File: rtl/mc6845_crtc.sv
// MC6845 CRT controller top: register file plus the character-rate
// timing chain (hc -> ra -> row -> vertical adjust) and output decode.
// Optional light-pen capture is built when MC6845_LIGHTPEN_EN is defined.
module mc6845_crtc
  import mc6845_pkg::*;
(
  input  logic        char_clk,
  input  logic        nRESET,
  input  logic        en,
  mc6845_if.slave     bus,
  input  logic        LPSTB,
  inout  wire  [7:0]  data_bus,
  output logic [13:0] framestore_adr,
  output logic [4:0]  scanline_row,
  output logic        display_en,
  output logic        h_sync,
  output logic        v_sync,
  output logic        cursor
);

  crtc_cfg_t   cfg;
  logic [7:0]  rdata;
  logic        rd_oe;
  logic [13:0] lpen_val;

  logic [7:0]  hc_q, hc_d;
  logic [4:0]  ra_q, ra_d;
  logic [6:0]  row_q, row_d;
  logic [4:0]  adj_q, adj_d;          // remaining vertical-adjust scanlines
  logic [13:0] row_start_q, row_start_d;
  logic        start_pend_q, start_pend_d;  // next cycle reloads R12:R13
  logic [5:0]  field_q, field_d;
  logic [4:0]  hs_rem_q, hs_rem_d;    // h_sync chars left after current
  logic [4:0]  vs_rem_q, vs_rem_d;    // v_sync scanlines left incl. current

  logic        line_end, in_adj, hs_start, vs_start, frame_end;
  logic [13:0] ma_base, adr_raw;
  logic        de_raw, blink_on, cur_raw;

  mc6845_regfile u_regfile (
    .clk_i      (char_clk),
    .en_i       (en),
    .bus        (bus),
    .wdata_i    (data_bus),
    .lpen_adr_i (lpen_val),
    .rdata_o    (rdata),
    .rd_oe_o    (rd_oe),
    .cfg_o      (cfg)
  );

  assign data_bus = rd_oe ? rdata : 8'hzz;

  assign line_end = (hc_q == cfg.h_total);
  assign in_adj   = (adj_q != 5'd0);
  assign ma_base  = start_pend_q ? cfg.start_addr : row_start_q;
  assign hs_start = (hc_q == cfg.h_sync_pos);
  assign vs_start = !in_adj && (row_q == cfg.v_sync_pos) &&
                    (ra_q == 5'd0) && (hc_q == 8'd0);

  // Next state of the counter chain; everything holds when en is low
  always_comb begin
    hc_d         = hc_q;
    ra_d         = ra_q;
    row_d        = row_q;
    adj_d        = adj_q;
    row_start_d  = row_start_q;
    start_pend_d = start_pend_q;
    field_d      = field_q;
    hs_rem_d     = hs_rem_q;
    vs_rem_d     = vs_rem_q;
    frame_end    = 1'b0;
    if (en) begin
      start_pend_d = 1'b0;
      row_start_d  = ma_base;
      hc_d         = line_end ? 8'd0 : hc_q + 8'd1;
      if (hc_q == cfg.h_disp && ra_q == cfg.max_ra && !in_adj)
        row_start_d = ma_base + {6'b0, cfg.h_disp};

      if (hs_start)
        hs_rem_d = sync_width(cfg.h_sync_w) - 5'd1;
      else if (hs_rem_q != 5'd0)
        hs_rem_d = hs_rem_q - 5'd1;

      if (vs_start)
        vs_rem_d = sync_width(cfg.v_sync_w) - (line_end ? 5'd1 : 5'd0);
      else if (line_end && vs_rem_q != 5'd0)
        vs_rem_d = vs_rem_q - 5'd1;

      if (line_end) begin
        if (in_adj) begin
          ra_d = ra_q + 5'd1;
          if (adj_q == 5'd1) frame_end = 1'b1;
          else               adj_d     = adj_q - 5'd1;
        end else if (ra_q == cfg.max_ra) begin
          ra_d = 5'd0;
          if (row_q == cfg.v_total) begin
            if (cfg.v_adj == 5'd0) frame_end = 1'b1;
            else                   adj_d     = cfg.v_adj;
          end else begin
            row_d = row_q + 7'd1;
          end
        end else begin
          ra_d = ra_q + 5'd1;
        end
      end

      if (frame_end) begin
        ra_d         = 5'd0;
        row_d        = 7'd0;
        adj_d        = 5'd0;
        start_pend_d = 1'b1;
        field_d      = field_q + 6'd1;
      end
    end
  end

  // Counter chain registers with synchronous active-low reset
  always_ff @(posedge char_clk) begin
    if (!nRESET) begin
      hc_q         <= '0;
      ra_q         <= '0;
      row_q        <= '0;
      adj_q        <= '0;
      row_start_q  <= '0;
      start_pend_q <= 1'b1;
      field_q      <= '0;
      hs_rem_q     <= '0;
      vs_rem_q     <= '0;
    end else begin
      hc_q         <= hc_d;
      ra_q         <= ra_d;
      row_q        <= row_d;
      adj_q        <= adj_d;
      row_start_q  <= row_start_d;
      start_pend_q <= start_pend_d;
      field_q      <= field_d;
      hs_rem_q     <= hs_rem_d;
      vs_rem_q     <= vs_rem_d;
    end
  end

  assign adr_raw = ma_base + {6'b0, hc_q};
  assign de_raw  = (hc_q < cfg.h_disp) && (row_q < cfg.v_disp) && !in_adj;

  // Cursor blink phase from the field counter
  always_comb begin
    blink_on = 1'b1;
    case (cfg.blink)
      BLINK_STEADY: blink_on = 1'b1;
      BLINK_OFF:    blink_on = 1'b0;
      BLINK_16:     blink_on = ~field_q[4];
      BLINK_32:     blink_on = ~field_q[5];
      default:      blink_on = 1'b1;
    endcase
  end

  assign cur_raw = de_raw && (adr_raw == cfg.cursor_addr) &&
                   (cfg.cur_start <= ra_q) && (ra_q <= cfg.cur_end) && blink_on;

  assign framestore_adr = nRESET ? adr_raw : 14'd0;
  assign scanline_row   = nRESET ? ra_q    : 5'd0;
  assign display_en     = nRESET & de_raw;
  assign h_sync         = nRESET & (hs_start | (hs_rem_q != 5'd0));
  assign v_sync         = nRESET & (vs_start | (vs_rem_q != 5'd0));
  assign cursor         = nRESET & cur_raw;

`ifdef MC6845_LIGHTPEN_EN
  logic        lpstb_q;
  logic [13:0] lpen_q;

  // Capture the refresh address on a light-pen rising edge
  always_ff @(posedge char_clk) begin
    if (en) begin
      lpstb_q <= LPSTB;
      if (LPSTB && !lpstb_q) lpen_q <= framestore_adr;
    end
  end

  assign lpen_val = lpen_q;
`else
  logic lpstb_unused;
  assign lpstb_unused = LPSTB;
  assign lpen_val     = 14'd0;
`endif

endmodule

// File: tb/tb_mc6845_crtc.sv
// Directed bench for mc6845_crtc using the standard test programming:
// 17-clock lines, 4 scanlines per row, 19 rows + 2 adjust lines.
module tb_mc6845_crtc;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        en = 1'b1;
  logic        lpstb = 1'b0;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = 8'h00;
  wire  [7:0]  data_bus;
  logic [13:0] adr;
  logic [4:0]  sr;
  logic        de, hs, vs, cur;

  int p = 0;
  int n_checks = 0;
  int n_pass = 0;

`ifdef MC6845_LIGHTPEN_EN
  localparam logic [7:0] LPEN_LO_EXP = 8'h85;
`else
  localparam logic [7:0] LPEN_LO_EXP = 8'h00;
`endif

  mc6845_if bus_if ();

  assign data_bus = drv_en ? drv_val : 8'hzz;

  mc6845_crtc dut (
    .char_clk       (clk),
    .nRESET         (nreset),
    .en             (en),
    .bus            (bus_if),
    .LPSTB          (lpstb),
    .data_bus       (data_bus),
    .framestore_adr (adr),
    .scanline_row   (sr),
    .display_en     (de),
    .h_sync         (hs),
    .v_sync         (vs),
    .cursor         (cur)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    if (en && nreset) p++;
  endtask

  task automatic goto(input int t);
    while (p < t) tick();
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [7:0] v);
    bus_if.nCS = 1'b0; bus_if.RnW = 1'b0; bus_if.RS = 1'b0;
    drv_en = 1'b1; drv_val = {3'b000, a};
    tick();
    bus_if.RS = 1'b1; drv_val = v;
    tick();
    bus_if.nCS = 1'b1; bus_if.RnW = 1'b1; drv_en = 1'b0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [7:0] v);
    bus_if.nCS = 1'b0; bus_if.RnW = 1'b0; bus_if.RS = 1'b0;
    drv_en = 1'b1; drv_val = {3'b000, a};
    tick();
    drv_en = 1'b0; bus_if.RnW = 1'b1; bus_if.RS = 1'b1;
    #1 v = data_bus;
    tick();
    bus_if.nCS = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] ra_tab [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                               5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
    logic [7:0] rv_tab [15] = '{8'd16, 8'd10, 8'd12, 8'h34, 8'd18, 8'd2, 8'd12, 8'd14,
                               8'd0, 8'd3, 8'h41, 8'd2, 8'h00, 8'h80, 8'h00};
    nreset = 1'b0;
    tick(); tick();
    for (int i = 0; i < 15; i++) reg_write(ra_tab[i], rv_tab[i]);
    reg_write(5'd15, 8'h80);
    #1;
    n_checks++; if (adr !== 14'd0) $display("FAIL reset_adr: got %0d exp 0", adr); else n_pass++;
    n_checks++; if (sr !== 5'd0) $display("FAIL reset_row: got %0d exp 0", sr); else n_pass++;
    n_checks++; if ({de, hs, vs, cur} !== 4'b0000) $display("FAIL reset_flags: got %b exp 0000", {de, hs, vs, cur}); else n_pass++;
    @(negedge clk);
    nreset = 1'b1; p = 0;
    #1;
    n_checks++; if (adr !== 14'd128) $display("FAIL release_adr: got %0d exp 128", adr); else n_pass++;
    n_checks++; if (sr !== 5'd0) $display("FAIL release_row: got %0d exp 0", sr); else n_pass++;
    n_checks++; if (de !== 1'b1) $display("FAIL release_de: got %0b exp 1", de); else n_pass++;
    n_checks++; if (cur !== 1'b0) $display("FAIL release_cursor: got %0b exp 0", cur); else n_pass++;
  endtask

  task automatic test_horizontal();
    logic e_de, e_hs;
    for (int h = 0; h < 17; h++) begin
      goto(h);
      e_de = (h < 10);
      e_hs = (h >= 12) && (h <= 15);
      n_checks++; if (de !== e_de) $display("FAIL h_de hc=%0d: got %0b exp %0b", h, de, e_de); else n_pass++;
      n_checks++; if (hs !== e_hs) $display("FAIL h_sync hc=%0d: got %0b exp %0b", h, hs, e_hs); else n_pass++;
      if (h < 10) begin
        n_checks++; if (adr !== 14'(128 + h)) $display("FAIL h_adr hc=%0d: got %0d exp %0d", h, adr, 128 + h); else n_pass++;
      end
    end
    goto(17);
    n_checks++; if (adr !== 14'd128) $display("FAIL h_wrap_adr: got %0d exp 128", adr); else n_pass++;
    n_checks++; if (sr !== 5'd1) $display("FAIL h_wrap_row: got %0d exp 1", sr); else n_pass++;
  endtask

  task automatic test_cursor();
    goto(17);
    n_checks++; if (cur !== 1'b1) $display("FAIL cursor_ra1: got %0b exp 1", cur); else n_pass++;
    goto(18);
    n_checks++; if (cur !== 1'b0) $display("FAIL cursor_ra1_hc1: got %0b exp 0", cur); else n_pass++;
    goto(34);
    n_checks++; if (cur !== 1'b1) $display("FAIL cursor_ra2: got %0b exp 1", cur); else n_pass++;
    goto(51);
    n_checks++; if (cur !== 1'b0) $display("FAIL cursor_ra3: got %0b exp 0", cur); else n_pass++;
  endtask

  task automatic test_addressing();
    int base_tab [2] = '{138, 148};
    for (int r = 1; r <= 2; r++) begin
      for (int ra = 0; ra < 4; ra++) begin
        goto(r * 68 + ra * 17);
        n_checks++; if (adr !== 14'(base_tab[r-1])) $display("FAIL addr_row%0d_ra%0d: got %0d exp %0d", r, ra, adr, base_tab[r-1]); else n_pass++;
        n_checks++; if (sr !== 5'(ra)) $display("FAIL scanline_row%0d_ra%0d: got %0d exp %0d", r, ra, sr, ra); else n_pass++;
        goto(r * 68 + ra * 17 + 9);
        n_checks++; if (adr !== 14'(base_tab[r-1] + 9)) $display("FAIL addr_row%0d_ra%0d_hc9: got %0d exp %0d", r, ra, adr, base_tab[r-1] + 9); else n_pass++;
      end
    end
  endtask

  task automatic test_vertical();
    goto(748);
    n_checks++; if (de !== 1'b1) $display("FAIL v_de_row11: got %0b exp 1", de); else n_pass++;
    goto(816);
    n_checks++; if (de !== 1'b0) $display("FAIL v_de_row12: got %0b exp 0", de); else n_pass++;
    goto(951);
    n_checks++; if (vs !== 1'b0) $display("FAIL v_sync_before: got %0b exp 0", vs); else n_pass++;
    goto(952);
    n_checks++; if (vs !== 1'b1) $display("FAIL v_sync_rise: got %0b exp 1", vs); else n_pass++;
    goto(1002);
    n_checks++; if (vs !== 1'b1) $display("FAIL v_sync_last: got %0b exp 1", vs); else n_pass++;
    goto(1003);
    n_checks++; if (vs !== 1'b0) $display("FAIL v_sync_end: got %0b exp 0", vs); else n_pass++;
    goto(1292);
    n_checks++; if (de !== 1'b0) $display("FAIL v_adjust_de: got %0b exp 0", de); else n_pass++;
    goto(1325);
    n_checks++; if (de !== 1'b0) $display("FAIL v_frame_last_de: got %0b exp 0", de); else n_pass++;
    goto(1326);
    n_checks++; if (adr !== 14'd128) $display("FAIL v_frame_adr: got %0d exp 128", adr); else n_pass++;
    n_checks++; if (sr !== 5'd0) $display("FAIL v_frame_row: got %0d exp 0", sr); else n_pass++;
    n_checks++; if (de !== 1'b1) $display("FAIL v_frame_de: got %0b exp 1", de); else n_pass++;
  endtask

  task automatic test_bus_lightpen();
    logic [7:0] rv;
    goto(1326 + 5);
    n_checks++; if (adr !== 14'd133) $display("FAIL lpen_adr: got %0d exp 133", adr); else n_pass++;
    lpstb = 1'b1;
    tick();
    lpstb = 1'b0;
    tick();
    reg_read(5'd16, rv);
    n_checks++; if (rv !== 8'h00) $display("FAIL read_r16: got %h exp 00", rv); else n_pass++;
    reg_read(5'd17, rv);
    n_checks++; if (rv !== LPEN_LO_EXP) $display("FAIL read_r17: got %h exp %h", rv, LPEN_LO_EXP); else n_pass++;
    reg_read(5'd14, rv);
    n_checks++; if (rv !== 8'h00) $display("FAIL read_r14: got %h exp 00", rv); else n_pass++;
    reg_read(5'd15, rv);
    n_checks++; if (rv !== 8'h80) $display("FAIL read_r15: got %h exp 80", rv); else n_pass++;
    reg_read(5'd0, rv);
    n_checks++; if (rv !== 8'h00) $display("FAIL read_r0: got %h exp 00", rv); else n_pass++;
    reg_read(5'd1, rv);
    n_checks++; if (rv !== 8'h00) $display("FAIL read_r1: got %h exp 00", rv); else n_pass++;
  endtask

  task automatic test_blink();
    int fr_tab [4] = '{15, 16, 31, 32};
    logic exp_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      goto(fr_tab[i] * 1326 + 17);
      n_checks++; if (cur !== exp_tab[i]) $display("FAIL blink_frame%0d: got %0b exp %0b", fr_tab[i], cur, exp_tab[i]); else n_pass++;
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (adr !== 14'd128) $display("FAIL hold_adr: got %0d exp 128", adr); else n_pass++;
    n_checks++; if (sr !== 5'd1) $display("FAIL hold_row: got %0d exp 1", sr); else n_pass++;
    en = 1'b1;
    tick();
    n_checks++; if (adr !== 14'd129) $display("FAIL resume_adr: got %0d exp 129", adr); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.nCS = 1'b1;
    bus_if.RnW = 1'b1;
    bus_if.RS  = 1'b0;
    test_reset();
    test_horizontal();
    test_cursor();
    test_addressing();
    test_vertical();
    test_bus_lightpen();
    test_blink();
    test_enable_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
